// File: rtl/soc_system_pll_pkg.sv
// Shared types and default timing for the pixel-clock PLL supervisor.
// Timing defaults assume a 50 MHz refclk.
package soc_system_pll_pkg;

    typedef logic [2:0] pll_sup_state_t;

    localparam pll_sup_state_t RESET_PLL = 3'd0;
    localparam pll_sup_state_t WAIT_LOCK = 3'd1;
    localparam pll_sup_state_t STABLE    = 3'd2;
    localparam pll_sup_state_t RUN       = 3'd3;
    localparam pll_sup_state_t FAULT     = 3'd4;

    localparam int unsigned DEF_RST_PULSE_CYCLES    = 16;
    localparam int unsigned DEF_LOCK_TIMEOUT_CYCLES = 50000;
    localparam int unsigned DEF_LOCK_STABLE_CYCLES  = 1024;
    localparam int unsigned DEF_MAX_RETRIES         = 3;
    localparam int unsigned DEF_CNT_W               = 8;

    // One shared timer covers every state, so size it for the longest window.
    function automatic int unsigned timer_width(input int unsigned a, input int unsigned b,
                                                input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/soc_system_pll_supervisor_if.sv
// Status/control bundle between the PLL supervisor and its PLL/pixel-domain consumers.
interface soc_system_pll_supervisor_if
    import soc_system_pll_pkg::*;
#(
    parameter int unsigned MAX_RETRIES = DEF_MAX_RETRIES,
    parameter int unsigned CNT_W       = DEF_CNT_W
);
    localparam int unsigned RETRY_W = $clog2(MAX_RETRIES + 1);

    logic               pll_locked;
    logic               restart;
    logic               pll_rst;
    logic               pix_rst_n;
    logic               lock_ok;
    logic               fault;
    logic [RETRY_W-1:0] retry_cnt;
    logic [CNT_W-1:0]   loss_cnt;

    modport master (
        input  pll_locked, restart,
        output pll_rst, pix_rst_n, lock_ok, fault, retry_cnt, loss_cnt
    );

    modport slave (
        output pll_locked, restart,
        input  pll_rst, pix_rst_n, lock_ok, fault, retry_cnt, loss_cnt
    );

endinterface

// File: rtl/soc_system_sync2.sv
// Generic two-flop synchronizer, asynchronously reset to 0.
module soc_system_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic meta_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            q      <= 1'b0;
        end else begin
            meta_q <= d;
            q      <= meta_q;
        end
    end

endmodule

// File: rtl/soc_system_pll_supervisor.sv
// Pixel-clock PLL supervisor: pulses the PLL reset, qualifies lock, releases the
// pixel-domain reset, and retries with a bounded count before a sticky fault.
module soc_system_pll_supervisor
    import soc_system_pll_pkg::*;
#(
    parameter int unsigned RST_PULSE_CYCLES    = DEF_RST_PULSE_CYCLES,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
    parameter int unsigned LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
    parameter int unsigned MAX_RETRIES         = DEF_MAX_RETRIES,
    parameter int unsigned CNT_W               = DEF_CNT_W
) (
    input  logic                          refclk,
    input  logic                          rst_n,
    soc_system_pll_supervisor_if.master   bus
);
    localparam int unsigned TIMER_W = timer_width(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES,
                                                  LOCK_STABLE_CYCLES);
    localparam int unsigned RETRY_W = $clog2(MAX_RETRIES + 1);

    localparam logic [TIMER_W-1:0] RST_LAST     = TIMER_W'(RST_PULSE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [TIMER_W-1:0] STABLE_LAST  = TIMER_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);

    logic               lk_s;
    pll_sup_state_t     state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [RETRY_W-1:0] retry_q, retry_d, retry_inc;
    logic [CNT_W-1:0]   loss_q, loss_d;
    logic               pll_rst_q, pix_rst_n_q, lock_ok_q, fault_q;

    soc_system_sync2 u_lock_sync (
        .clk   (refclk),
        .rst_n (rst_n),
        .d     (bus.pll_locked),
        .q     (lk_s)
    );

    assign retry_inc = retry_q + 1'b1;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        retry_d = retry_q;
        loss_d  = loss_q;

        // Loss is counted even when a restart lands on the same cycle.
        if (state_q == RUN && !lk_s && loss_q != '1) begin
            loss_d = loss_q + 1'b1;
        end

        if (bus.restart) begin
            state_d = RESET_PLL;
            timer_d = '0;
            retry_d = '0;
        end else begin
            case (state_q)
                RESET_PLL: begin
                    if (timer_q == RST_LAST) begin
                        state_d = WAIT_LOCK;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                WAIT_LOCK: begin
                    if (lk_s) begin
                        state_d = STABLE;
                        timer_d = '0;
                    end else if (timer_q == TIMEOUT_LAST) begin
                        timer_d = '0;
                        retry_d = retry_inc;
                        state_d = (retry_inc == RETRY_LIMIT) ? FAULT : RESET_PLL;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                STABLE: begin
                    // A dropout only restarts qualification; it is not a failed attempt.
                    if (!lk_s) begin
                        state_d = WAIT_LOCK;
                        timer_d = '0;
                    end else if (timer_q == STABLE_LAST) begin
                        state_d = RUN;
                        timer_d = '0;
                        retry_d = '0;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                RUN: begin
                    if (!lk_s) begin
                        state_d = RESET_PLL;
                        timer_d = '0;
                    end
                end
                FAULT: begin
                end
                default: begin
                    state_d = RESET_PLL;
                    timer_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RESET_PLL;
            timer_q     <= '0;
            retry_q     <= '0;
            loss_q      <= '0;
            pll_rst_q   <= 1'b1;
            pix_rst_n_q <= 1'b0;
            lock_ok_q   <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            retry_q     <= retry_d;
            loss_q      <= loss_d;
            pll_rst_q   <= (state_d == RESET_PLL);
            pix_rst_n_q <= (state_d == RUN);
            lock_ok_q   <= (state_d == RUN);
            fault_q     <= (state_d == FAULT);
        end
    end

    assign bus.pll_rst   = pll_rst_q;
    assign bus.pix_rst_n = pix_rst_n_q;
    assign bus.lock_ok   = lock_ok_q;
    assign bus.fault     = fault_q;
    assign bus.retry_cnt = retry_q;
    assign bus.loss_cnt  = loss_q;

endmodule

// File: tb/tb_soc_system_pll_supervisor.sv
// Directed bench for the PLL supervisor with a phase-level reference model.
module tb_soc_system_pll_supervisor;
    import soc_system_pll_pkg::*;

    localparam int unsigned RP = 4;
    localparam int unsigned TO = 20;
    localparam int unsigned ST = 8;
    localparam int unsigned MR = 3;
    localparam int unsigned CW = 2;

    localparam int PH_PULSE = 0;
    localparam int PH_WAIT  = 1;
    localparam int PH_QUAL  = 2;
    localparam int PH_RUN   = 3;
    localparam int PH_FAULT = 4;

    logic refclk = 1'b0;
    logic rst_n;

    always #5 refclk = ~refclk;

    soc_system_pll_supervisor_if #(.MAX_RETRIES(MR), .CNT_W(CW)) bus ();

    soc_system_pll_supervisor #(
        .RST_PULSE_CYCLES    (RP),
        .LOCK_TIMEOUT_CYCLES (TO),
        .LOCK_STABLE_CYCLES  (ST),
        .MAX_RETRIES         (MR),
        .CNT_W               (CW)
    ) dut (
        .refclk (refclk),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: phase, cycles spent in the phase, failed attempts, losses.
    int   m_phase, m_age, m_fails, m_losses;
    logic m_d1, m_d2;

    task automatic model_reset();
        m_phase = PH_PULSE; m_age = 0; m_fails = 0; m_losses = 0;
        m_d1 = 1'b0; m_d2 = 1'b0;
    endtask

    task automatic model_step(input logic locked, input logic restart);
        logic lk;
        lk = m_d2;
        if (m_phase == PH_RUN && !lk && m_losses < (1 << CW) - 1) m_losses++;
        if (restart) begin
            m_phase = PH_PULSE; m_age = 0; m_fails = 0;
        end else begin
            case (m_phase)
                PH_PULSE: begin
                    m_age++;
                    if (m_age == RP) begin m_phase = PH_WAIT; m_age = 0; end
                end
                PH_WAIT: begin
                    if (lk) begin
                        m_phase = PH_QUAL; m_age = 0;
                    end else begin
                        m_age++;
                        if (m_age == TO) begin
                            m_fails++;
                            m_age = 0;
                            m_phase = (m_fails == MR) ? PH_FAULT : PH_PULSE;
                        end
                    end
                end
                PH_QUAL: begin
                    if (!lk) begin
                        m_phase = PH_WAIT; m_age = 0;
                    end else begin
                        m_age++;
                        if (m_age == ST) begin m_phase = PH_RUN; m_age = 0; m_fails = 0; end
                    end
                end
                PH_RUN: begin
                    if (!lk) begin m_phase = PH_PULSE; m_age = 0; end
                end
                default: begin
                end
            endcase
        end
        m_d2 = m_d1;
        m_d1 = locked;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge refclk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step(bus.pll_locked, bus.restart);
        end
    end

    initial begin
        forever begin
            logic [3:0] act, exp;
            @(negedge refclk);
            act = {bus.pll_rst, bus.pix_rst_n, bus.lock_ok, bus.fault};
            exp = {m_phase == PH_PULSE, m_phase == PH_RUN, m_phase == PH_RUN,
                   m_phase == PH_FAULT};
            checks++;
            if (act === exp && int'(bus.retry_cnt) == m_fails && int'(bus.loss_cnt) == m_losses)
                passes++;
            else
                $display("FAIL model t=%0t: rst/pix/ok/fault=%b retry=%0d loss=%0d, expected %b retry=%0d loss=%0d",
                         $time, act, bus.retry_cnt, bus.loss_cnt, exp, m_fails, m_losses);
        end
    end

    task automatic tick(input int k);
        repeat (k) begin
            @(posedge refclk);
            #1;
        end
    endtask

    task automatic wait_pll_rst(input logic lvl, input int max, output int n);
        n = 0;
        while (bus.pll_rst !== lvl && n < max) begin tick(1); n++; end
        check("wait_pll_rst", bus.pll_rst, lvl);
    endtask

    task automatic wait_pix(input logic lvl, input int max, output int n);
        n = 0;
        while (bus.pix_rst_n !== lvl && n < max) begin tick(1); n++; end
        check("wait_pix_rst_n", bus.pix_rst_n, lvl);
    endtask

    logic saw_rst, saw_retry;

    task automatic tick_mon();
        tick(1);
        if (bus.pll_rst) saw_rst = 1'b1;
        if (bus.retry_cnt != 0) saw_retry = 1'b1;
    endtask

    int exp_loss [3] = '{2, 3, 3};

    initial begin
        int n, k;
        rst_n = 1'b0;
        bus.pll_locked = 1'b0;
        bus.restart = 1'b0;
        tick(3);
        check("rst_pll_rst", bus.pll_rst, 1);
        check("rst_pix_rst_n", bus.pix_rst_n, 0);
        check("rst_lock_ok", bus.lock_ok, 0);
        check("rst_fault", bus.fault, 0);
        check("rst_retry", bus.retry_cnt, 0);
        check("rst_loss", bus.loss_cnt, 0);

        // Nominal bring-up
        rst_n = 1'b1;
        wait_pll_rst(1'b0, 20, n);
        check("pll_rst_width", n, RP);
        tick(5);
        bus.pll_locked = 1'b1;
        wait_pix(1'b1, 40, n);
        check("bringup_latency", n, 11);
        check("bringup_lock_ok", bus.lock_ok, 1);
        check("bringup_retry", bus.retry_cnt, 0);

        // First lock loss in RUN
        bus.pll_locked = 1'b0;
        tick(2);
        check("loss_pix_hold", bus.pix_rst_n, 1);
        tick(1);
        check("loss_pix_rst_n", bus.pix_rst_n, 0);
        check("loss_pll_rst", bus.pll_rst, 1);
        check("loss_cnt_1", bus.loss_cnt, 1);

        // Dropout during qualification
        wait_pll_rst(1'b0, 20, n);
        saw_rst = 1'b0;
        saw_retry = 1'b0;
        bus.pll_locked = 1'b1;
        repeat (5) tick_mon();
        bus.pll_locked = 1'b0;
        tick_mon();
        bus.pll_locked = 1'b1;
        n = 0;
        while (!bus.pix_rst_n && n < 40) begin tick_mon(); n++; end
        check("glitch_release", n, 11);
        check("glitch_no_pll_rst", saw_rst, 0);
        check("glitch_no_retry", saw_retry, 0);

        // Further losses saturate the counter
        for (int i = 0; i < 3; i++) begin
            bus.pll_locked = 1'b0;
            tick(3);
            check("loss_cnt_sat", bus.loss_cnt, exp_loss[i]);
            bus.pll_locked = 1'b1;
            wait_pix(1'b1, 40, n);
        end

        // Lock never returns: retries then fault
        bus.pll_locked = 1'b0;
        wait_pll_rst(1'b1, 10, n);
        check("loss_to_reset", n, 3);
        for (int p = 0; p < 3; p++) begin
            check("pulse_retry", bus.retry_cnt, p);
            wait_pll_rst(1'b0, 10, n);
            check("pulse_width", n, RP);
            n = 0;
            while (!bus.pll_rst && !bus.fault && n < 40) begin tick(1); n++; end
            check("pulse_gap", n, TO);
            check("gap_retry", bus.retry_cnt, p + 1);
        end
        check("fault_set", bus.fault, 1);
        check("fault_pll_rst", bus.pll_rst, 0);
        check("fault_loss", bus.loss_cnt, 3);
        bus.pll_locked = 1'b1;
        tick(10);
        check("fault_sticky", bus.fault, 1);
        check("fault_sticky_pll_rst", bus.pll_rst, 0);
        check("fault_sticky_pix", bus.pix_rst_n, 0);

        // Software restart out of FAULT
        bus.restart = 1'b1;
        tick(1);
        bus.restart = 1'b0;
        check("restart_pll_rst", bus.pll_rst, 1);
        check("restart_fault", bus.fault, 0);
        check("restart_retry", bus.retry_cnt, 0);
        wait_pix(1'b1, 40, k);
        check("restart_release", k + 1, 14);
        check("restart_loss", bus.loss_cnt, 3);

        // Asynchronous reset while qualifying lock
        bus.pll_locked = 1'b0;
        tick(3);
        check("prep_pll_rst", bus.pll_rst, 1);
        bus.pll_locked = 1'b1;
        wait_pll_rst(1'b0, 10, n);
        tick(3);
        check("prep_in_stable", bus.pix_rst_n, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_pll_rst", bus.pll_rst, 1);
        check("async_pix_rst_n", bus.pix_rst_n, 0);
        check("async_loss", bus.loss_cnt, 0);
        check("async_retry", bus.retry_cnt, 0);
        tick(2);
        rst_n = 1'b1;
        wait_pix(1'b1, 40, n);
        check("post_reset_release", n, 13);
        tick(2);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
